// File: rtl/serial_link_pkg.sv
// Shared types and constants for the serial link meshed-network blocks.
// Holds the fetch sequencer's FSM encoding and running descriptor layout.
package serial_link_pkg;

    localparam int unsigned MeshedFetchMaxBurst = 16;
    localparam int unsigned MeshedFetch4kBytes  = 4096;

    localparam int unsigned MfAddrWidth = 32;
    localparam int unsigned MfLenWidth  = 32;
    localparam int unsigned MfChipWidth = 4;
    localparam int unsigned MfDirWidth  = 2;

    typedef enum logic [2:0] {
        FetchIdle   = 3'd0,
        FetchIssue  = 3'd1,
        FetchStream = 3'd2,
        FetchDrain  = 3'd3,
        FetchDone   = 3'd4
    } fetch_state_e;

    // While a descriptor is in flight, src/dst are cursors and len counts
    // the beats still to be received.
    typedef struct packed {
        logic [MfAddrWidth-1:0] src;
        logic [MfAddrWidth-1:0] dst;
        logic [MfLenWidth-1:0]  len;
        logic [MfChipWidth-1:0] chip;
        logic [MfDirWidth-1:0]  dir;
    } fetch_desc_t;

endpackage

// File: rtl/meshed_fetch_burst_calc.sv
// Burst sizing for the meshed fetch sequencer: the next AR length is the
// smallest of remaining beats, the burst cap and the room left in the 4KB page.
module meshed_fetch_burst_calc
    import serial_link_pkg::*;
#(
    parameter int unsigned LenWidth      = 32,
    parameter int unsigned BeatBytes     = 32,
    parameter int unsigned MaxBurstBeats = MeshedFetchMaxBurst
) (
    input  logic [LenWidth-1:0] i_remaining,
    input  logic [11:0]         i_src_page_off,
    output logic [8:0]          o_burst
);

    localparam int unsigned BeatShift = $clog2(BeatBytes);
    localparam logic [12:0] MaxB      = 13'(MaxBurstBeats);
    localparam logic [12:0] PageBytes = 13'(MeshedFetch4kBytes);

    logic [12:0] w_room_bytes;
    logic [12:0] w_room_beats;
    logic [12:0] w_cap;

    assign w_room_bytes = PageBytes - {1'b0, i_src_page_off};
    assign w_room_beats = w_room_bytes >> BeatShift;
    assign w_cap        = (w_room_beats < MaxB) ? w_room_beats : MaxB;

    always_comb begin
        o_burst = 9'(w_cap);
        if (i_remaining < LenWidth'(w_cap)) begin
            o_burst = 9'(i_remaining);
        end
    end

endmodule

// File: rtl/meshed_fetch_ctrl.sv
// Meshed-network data fetcher: splits one descriptor into 4KB-safe AXI read
// bursts and forwards each returned beat as a tagged egress packet beat.
module meshed_fetch_ctrl
    import serial_link_pkg::*;
#(
    parameter int unsigned AddrWidth     = MfAddrWidth,
    parameter int unsigned DataWidth     = 256,
    parameter int unsigned LenWidth      = MfLenWidth,
    parameter int unsigned MaxBurstBeats = MeshedFetchMaxBurst,
    parameter int unsigned ChipIdWidth   = MfChipWidth,
    parameter int unsigned DirWidth      = MfDirWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   desc_valid_i,
    output logic                   desc_ready_o,
    input  logic [AddrWidth-1:0]   desc_src_addr_i,
    input  logic [AddrWidth-1:0]   desc_dst_addr_i,
    input  logic [LenWidth-1:0]    desc_len_i,
    input  logic [ChipIdWidth-1:0] desc_dst_chip_i,
    input  logic [DirWidth-1:0]    desc_dir_i,
    output logic                   ar_valid_o,
    input  logic                   ar_ready_i,
    output logic [AddrWidth-1:0]   ar_addr_o,
    output logic [7:0]             ar_len_o,
    input  logic                   r_valid_i,
    output logic                   r_ready_o,
    input  logic [DataWidth-1:0]   r_data_i,
    input  logic [1:0]             r_resp_i,
    input  logic                   r_last_i,
    output logic                   pkt_valid_o,
    input  logic                   pkt_ready_i,
    output logic [DataWidth-1:0]   pkt_data_o,
    output logic [AddrWidth-1:0]   pkt_dst_addr_o,
    output logic [ChipIdWidth-1:0] pkt_dst_chip_o,
    output logic [DirWidth-1:0]    pkt_dir_o,
    output logic                   pkt_last_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int unsigned BeatBytes = DataWidth / 8;
    localparam int unsigned BeatShift = $clog2(BeatBytes);
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(BeatBytes - 1);

    fetch_state_e         r_state;
    fetch_desc_t          r_desc;
    logic [8:0]           r_burst;
    logic                 r_err;
    logic                 r_pkt_valid;
    logic [DataWidth-1:0] r_pkt_data;
    logic [AddrWidth-1:0] r_pkt_dst;
    logic                 r_pkt_last;

    logic [LenWidth-1:0]  w_beats;
    logic [LenWidth-1:0]  w_remaining_nxt;
    logic [8:0]           w_burst;
    logic [AddrWidth-1:0] w_src_step;
    logic                 w_r_hs;

    assign w_beats = (desc_len_i >> BeatShift)
                   + LenWidth'(|desc_len_i[BeatShift-1:0]);
    assign w_remaining_nxt = r_desc.len - LenWidth'(1);
    assign w_src_step      = AddrWidth'(r_burst) << BeatShift;
    assign w_r_hs          = r_valid_i && r_ready_o;

    meshed_fetch_burst_calc #(
        .LenWidth      (LenWidth),
        .BeatBytes     (BeatBytes),
        .MaxBurstBeats (MaxBurstBeats)
    ) u_burst_calc (
        .i_remaining    (r_desc.len),
        .i_src_page_off (r_desc.src[11:0]),
        .o_burst        (w_burst)
    );

    // Outputs are forced low while reset is asserted.
    assign desc_ready_o   = (r_state == FetchIdle) && !rst_i;
    assign ar_valid_o     = (r_state == FetchIssue);
    assign ar_addr_o      = ar_valid_o ? r_desc.src : '0;
    assign ar_len_o       = ar_valid_o ? 8'(w_burst - 9'd1) : 8'd0;
    assign r_ready_o      = (r_state == FetchStream)
                          && (!r_pkt_valid || pkt_ready_i);
    assign pkt_valid_o    = r_pkt_valid;
    assign pkt_data_o     = r_pkt_data;
    assign pkt_dst_addr_o = r_pkt_dst;
    assign pkt_dst_chip_o = r_desc.chip;
    assign pkt_dir_o      = r_desc.dir;
    assign pkt_last_o     = r_pkt_last;
    assign busy_o         = (r_state != FetchIdle);
    assign done_o         = (r_state == FetchDone);
    assign err_o          = (r_state == FetchDone) && r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= FetchIdle;
            r_desc      <= '0;
            r_burst     <= '0;
            r_err       <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_pkt_data  <= '0;
            r_pkt_dst   <= '0;
            r_pkt_last  <= 1'b0;
        end else begin
            if (w_r_hs) begin
                r_pkt_valid <= 1'b1;
                r_pkt_data  <= r_data_i;
                r_pkt_dst   <= r_desc.dst;
                r_pkt_last  <= (w_remaining_nxt == '0);
            end else if (pkt_ready_i) begin
                r_pkt_valid <= 1'b0;
            end

            unique case (r_state)
                FetchIdle: begin
                    if (desc_valid_i) begin
                        r_desc.src  <= desc_src_addr_i & AlignMask;
                        r_desc.dst  <= desc_dst_addr_i & AlignMask;
                        r_desc.len  <= w_beats;
                        r_desc.chip <= desc_dst_chip_i;
                        r_desc.dir  <= desc_dir_i;
                        r_state     <= (w_beats == '0) ? FetchDone : FetchIssue;
                    end
                end
                FetchIssue: begin
                    if (ar_ready_i) begin
                        r_burst <= w_burst;
                        r_state <= FetchStream;
                    end
                end
                FetchStream: begin
                    if (w_r_hs) begin
                        r_desc.dst <= r_desc.dst + AddrWidth'(BeatBytes);
                        r_desc.len <= w_remaining_nxt;
                        if (r_resp_i != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        if (r_last_i) begin
                            if (w_remaining_nxt != '0) begin
                                r_desc.src <= r_desc.src + w_src_step;
                                r_state    <= FetchIssue;
                            end else begin
                                r_state <= FetchDrain;
                            end
                        end
                    end
                end
                FetchDrain: begin
                    if (!r_pkt_valid || pkt_ready_i) begin
                        r_state <= FetchDone;
                    end
                end
                FetchDone: begin
                    r_err   <= 1'b0;
                    r_state <= FetchIdle;
                end
                default: r_state <= FetchIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_meshed_fetch_ctrl.sv
// Scoreboard bench for meshed_fetch_ctrl: directed descriptors, an AXI read
// slave model, and a monitor that checks AR, packet and done traffic.
module tb_meshed_fetch_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         desc_valid_i;
    logic         desc_ready_o;
    logic [31:0]  desc_src_addr_i;
    logic [31:0]  desc_dst_addr_i;
    logic [31:0]  desc_len_i;
    logic [3:0]   desc_dst_chip_i;
    logic [1:0]   desc_dir_i;
    logic         ar_valid_o;
    logic         ar_ready_i;
    logic [31:0]  ar_addr_o;
    logic [7:0]   ar_len_o;
    logic         r_valid_i;
    logic         r_ready_o;
    logic [255:0] r_data_i;
    logic [1:0]   r_resp_i;
    logic         r_last_i;
    logic         pkt_valid_o;
    logic         pkt_ready_i;
    logic [255:0] pkt_data_o;
    logic [31:0]  pkt_dst_addr_o;
    logic [3:0]   pkt_dst_chip_o;
    logic [1:0]   pkt_dir_o;
    logic         pkt_last_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    always #5 clk_i = ~clk_i;

    meshed_fetch_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .desc_valid_i    (desc_valid_i),
        .desc_ready_o    (desc_ready_o),
        .desc_src_addr_i (desc_src_addr_i),
        .desc_dst_addr_i (desc_dst_addr_i),
        .desc_len_i      (desc_len_i),
        .desc_dst_chip_i (desc_dst_chip_i),
        .desc_dir_i      (desc_dir_i),
        .ar_valid_o      (ar_valid_o),
        .ar_ready_i      (ar_ready_i),
        .ar_addr_o       (ar_addr_o),
        .ar_len_o        (ar_len_o),
        .r_valid_i       (r_valid_i),
        .r_ready_o       (r_ready_o),
        .r_data_i        (r_data_i),
        .r_resp_i        (r_resp_i),
        .r_last_i        (r_last_i),
        .pkt_valid_o     (pkt_valid_o),
        .pkt_ready_i     (pkt_ready_i),
        .pkt_data_o      (pkt_data_o),
        .pkt_dst_addr_o  (pkt_dst_addr_o),
        .pkt_dst_chip_o  (pkt_dst_chip_o),
        .pkt_dir_o       (pkt_dir_o),
        .pkt_last_o      (pkt_last_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  dst;
        logic [3:0]   chip;
        logic [1:0]   dir;
        logic         last;
    } pk_t;

    ar_t  exp_ar[$];
    pk_t  exp_pk[$];
    logic exp_done[$];
    ar_t  sl_q[$];

    int          tests = 0;
    int          fails = 0;
    int          n_acc = 0;
    int          n_done = 0;
    bit          rnd = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    function automatic logic [255:0] mkdata(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1,
                a, ~a, a ^ 32'hC3C3_C3C3, a + 32'd7};
    endfunction

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t t;
        t.addr = a;
        t.len  = l;
        exp_ar.push_back(t);
    endtask

    task automatic expect_desc(input logic [31:0] s, input logic [31:0] d,
                               input int n, input logic [3:0] c,
                               input logic [1:0] dr, input logic e);
        pk_t p;
        for (int i = 0; i < n; i++) begin
            p.data = mkdata(s + 32 * i);
            p.dst  = d + 32 * i;
            p.chip = c;
            p.dir  = dr;
            p.last = (i == n - 1);
            exp_pk.push_back(p);
        end
        exp_done.push_back(e);
    endtask

    // Caller must be at posedge+#1; returns at posedge+#1 after acceptance.
    task automatic send(input logic [31:0] s, input logic [31:0] d,
                        input logic [31:0] len, input logic [3:0] c,
                        input logic [1:0] dr);
        bit ok = 1'b0;
        desc_src_addr_i = s;
        desc_dst_addr_i = d;
        desc_len_i      = len;
        desc_dst_chip_i = c;
        desc_dir_i      = dr;
        desc_valid_i    = 1'b1;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk_i);
            if (desc_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("desc_accept_timeout", 1, 0);
        else check("accept_after_prev_done", n_done, n_acc);
        @(posedge clk_i);
        #1;
        desc_valid_i = 1'b0;
        n_acc++;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk_i);
            if (n_done == n_acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 1, 0);
        @(posedge clk_i);
        #1;
        check("ar_all_seen", exp_ar.size(), 0);
        check("pkt_all_seen", exp_pk.size(), 0);
    endtask

    // AXI read slave plus ready drivers; acts on handshakes seen at negedge.
    initial begin
        bit  hs_r;
        bit  hs_ar;
        ar_t cap;
        int  k = 0;
        logic [31:0] a;
        forever begin
            @(negedge clk_i);
            hs_r     = r_valid_i && r_ready_o;
            hs_ar    = ar_valid_o && ar_ready_i;
            cap.addr = ar_addr_o;
            cap.len  = ar_len_o;
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                sl_q.delete();
                k = 0;
                r_valid_i = 1'b0;
                r_last_i  = 1'b0;
            end else begin
                if (hs_r && sl_q.size() != 0) begin
                    if (k == int'(sl_q[0].len)) begin
                        void'(sl_q.pop_front());
                        k = 0;
                    end else begin
                        k++;
                    end
                end
                if (hs_ar) sl_q.push_back(cap);
                pkt_ready_i = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
                ar_ready_i  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (sl_q.size() != 0 &&
                    ((r_valid_i && !hs_r) || !rnd || $urandom_range(0, 3) != 0)) begin
                    a         = sl_q[0].addr + 32 * k;
                    r_valid_i = 1'b1;
                    r_data_i  = mkdata(a);
                    r_last_i  = (k == int'(sl_q[0].len));
                    r_resp_i  = (a == err_addr) ? 2'b10 : 2'b00;
                end else begin
                    r_valid_i = 1'b0;
                    r_last_i  = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every observed output event.
    initial begin
        bit           prev_rhs = 1'b0;
        bit           prev_stall = 1'b0;
        bit           prev_done = 1'b0;
        logic [255:0] prev_data = '0;
        ar_t          a;
        pk_t          p;
        logic         e;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_rhs   = 1'b0;
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (prev_rhs) check("r_to_pkt_latency", pkt_valid_o, 1);
                if (prev_stall) begin
                    check("stall_valid_held", pkt_valid_o, 1);
                    check("stall_data_held", pkt_data_o, prev_data);
                end
                if (prev_done) check("done_one_cycle", done_o, 0);
                if (pkt_valid_o && !pkt_ready_i)
                    check("r_ready_when_full", r_ready_o, 0);
                if (ar_valid_o && ar_ready_i) begin
                    if (exp_ar.size() == 0) begin
                        check("ar_unexpected", {ar_addr_o, ar_len_o}, 0);
                    end else begin
                        a = exp_ar.pop_front();
                        check("ar_addr", ar_addr_o, a.addr);
                        check("ar_len", ar_len_o, a.len);
                    end
                end
                if (pkt_valid_o && pkt_ready_i) begin
                    if (exp_pk.size() == 0) begin
                        check("pkt_unexpected", pkt_dst_addr_o, 32'hDEAD_BEEF);
                    end else begin
                        p = exp_pk.pop_front();
                        check("pkt_data", pkt_data_o, p.data);
                        check("pkt_dst_addr", pkt_dst_addr_o, p.dst);
                        check("pkt_tag", {pkt_dst_chip_o, pkt_dir_o},
                              {p.chip, p.dir});
                        check("pkt_last", pkt_last_o, p.last);
                    end
                end
                if (done_o) begin
                    n_done++;
                    if (exp_done.size() == 0) begin
                        check("done_unexpected", done_o, 0);
                    end else begin
                        e = exp_done.pop_front();
                        check("done_err", err_o, e);
                    end
                end
                prev_rhs   = r_valid_i && r_ready_o;
                prev_stall = pkt_valid_o && !pkt_ready_i;
                prev_done  = done_o;
                prev_data  = pkt_data_o;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst_i           = 1'b1;
        desc_valid_i    = 1'b0;
        desc_src_addr_i = '0;
        desc_dst_addr_i = '0;
        desc_len_i      = '0;
        desc_dst_chip_i = '0;
        desc_dir_i      = '0;
        ar_ready_i      = 1'b1;
        pkt_ready_i     = 1'b1;
        r_valid_i       = 1'b0;
        r_data_i        = '0;
        r_resp_i        = '0;
        r_last_i        = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_ctrl_outputs",
              {desc_ready_o, ar_valid_o, ar_addr_o, ar_len_o, r_ready_o,
               pkt_valid_o, pkt_dst_addr_o, pkt_dst_chip_o, pkt_dir_o,
               pkt_last_o, busy_o, done_o, err_o}, 0);
        check("reset_pkt_data", pkt_data_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Single beat, plus accept-to-AR latency.
        push_ar(32'h0, 8'd0);
        expect_desc(32'h0, 32'h2000, 1, 4'd3, 2'd1, 1'b0);
        send(32'h0, 32'h2000, 32'd32, 4'd3, 2'd1);
        @(negedge clk_i);
        check("accept_to_ar_valid", ar_valid_o, 1);
        wait_done();

        // Two full 16-beat bursts.
        push_ar(32'h000, 8'd15);
        push_ar(32'h200, 8'd15);
        expect_desc(32'h0, 32'h4000, 32, 4'd5, 2'd2, 1'b0);
        send(32'h0, 32'h4000, 32'd1024, 4'd5, 2'd2);
        wait_done();

        // Split at the 4KB boundary.
        push_ar(32'h0FC0, 8'd1);
        push_ar(32'h1000, 8'd5);
        expect_desc(32'h0FC0, 32'h6000, 8, 4'd1, 2'd0, 1'b0);
        send(32'h0FC0, 32'h6000, 32'd256, 4'd1, 2'd0);
        wait_done();

        // Zero length: straight to done on the following cycle.
        expect_desc(32'h100, 32'h100, 0, 4'd2, 2'd3, 1'b0);
        send(32'h100, 32'h100, 32'd0, 4'd2, 2'd3);
        @(negedge clk_i);
        check("len0_done_next_cycle", done_o, 1);
        wait_done();

        // len=33 rounds up to 2 beats; unaligned addresses are truncated.
        push_ar(32'h40, 8'd1);
        expect_desc(32'h40, 32'h80, 2, 4'd4, 2'd1, 1'b0);
        send(32'h47, 32'h81, 32'd33, 4'd4, 2'd1);
        wait_done();

        // Backpressure at ~30% ready with random AR/R gaps.
        rnd = 1'b1;
        push_ar(32'h1000, 8'd15);
        expect_desc(32'h1000, 32'h8000, 16, 4'd9, 2'd2, 1'b0);
        send(32'h1000, 32'h8000, 32'd512, 4'd9, 2'd2);
        wait_done();
        rnd = 1'b0;

        // SLVERR on beat 5 of 8, then a clean descriptor.
        err_addr = 32'h3080;
        push_ar(32'h3000, 8'd7);
        expect_desc(32'h3000, 32'hA000, 8, 4'd6, 2'd3, 1'b1);
        send(32'h3000, 32'hA000, 32'd256, 4'd6, 2'd3);
        wait_done();
        err_addr = 32'hFFFF_FFFF;
        push_ar(32'h3100, 8'd1);
        expect_desc(32'h3100, 32'hB000, 2, 4'd6, 2'd3, 1'b0);
        send(32'h3100, 32'hB000, 32'd64, 4'd6, 2'd3);
        wait_done();

        // Back-to-back triggers: the second is held off until the first ends.
        push_ar(32'h400, 8'd2);
        push_ar(32'h500, 8'd0);
        expect_desc(32'h400, 32'hC000, 3, 4'd7, 2'd0, 1'b0);
        expect_desc(32'h500, 32'hD000, 1, 4'd8, 2'd1, 1'b0);
        send(32'h400, 32'hC000, 32'd96, 4'd7, 2'd0);
        send(32'h500, 32'hD000, 32'd32, 4'd8, 2'd1);
        wait_done();

        // Reset in the middle of a descriptor abandons it.
        rnd = 1'b1;
        push_ar(32'h000, 8'd15);
        push_ar(32'h200, 8'd15);
        expect_desc(32'h0, 32'hE000, 32, 4'd9, 2'd2, 1'b0);
        send(32'h0, 32'hE000, 32'd1024, 4'd9, 2'd2);
        repeat (12) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("midreset_ctrl_outputs",
              {desc_ready_o, ar_valid_o, ar_addr_o, ar_len_o, r_ready_o,
               pkt_valid_o, pkt_dst_addr_o, pkt_dst_chip_o, pkt_dir_o,
               pkt_last_o, busy_o, done_o, err_o}, 0);
        check("midreset_pkt_data", pkt_data_o, 0);
        @(negedge clk_i);
        exp_ar.delete();
        exp_pk.delete();
        exp_done.delete();
        n_acc = n_done;
        d = n_done;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rnd   = 1'b0;
        repeat (30) @(posedge clk_i);
        #1;
        check("no_done_after_reset", n_done, d);
        check("idle_after_reset", busy_o, 0);

        // Recovery after reset.
        push_ar(32'h20, 8'd0);
        expect_desc(32'h20, 32'hF000, 1, 4'd1, 2'd1, 1'b0);
        send(32'h20, 32'hF000, 32'd32, 4'd1, 2'd1);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
